flex_pts_tx: RTL
================

FLEX_PTS_TX -- requirements
Module: flex_pts_tx

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8: data bits per frame, legal range 2..32.
REQ-002 SHALL have parameter SHIFT_MSB, default 1: 1 = MSB sent first, 0 = LSB sent first.
REQ-003 SHALL have parameter BIT_PERIOD, default 4: clock cycles per serial bit, legal range 1..1024.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data_in, input, NUM_BITS bits: word to transmit, sampled only on accept.
REQ-007 SHALL have port data_valid, input, 1 bit: word on data_in is offered.
REQ-008 SHALL have port data_ready, output, 1 bit: block can accept a word this cycle.
REQ-009 SHALL have port serial_out, output, 1 bit: framed serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse in the last cycle of the stop bit.

Function
REQ-012 SHALL accept a word on any rising edge where data_valid and data_ready are both 1, capturing data_in into the shift register.
REQ-013 SHALL run the FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START on a back-to-back accept.
REQ-014 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly BIT_PERIOD cycles, timed by a bit-period counter that restarts at every bit boundary.
REQ-015 SHALL drive serial_out as follows: 1 in IDLE; 0 in START; the current shift-register end bit in DATA; parity bit in PARITY; 1 in STOP.
REQ-016 SHALL drive serial_out to the start bit 0 on the cycle after the accept edge (latency 1).
REQ-017 SHALL shift the register one position, filling with 1, at each DATA bit boundary, and SHALL count exactly NUM_BITS data bits.
REQ-018 SHALL assert data_ready in IDLE and in the final cycle of STOP only; an accept in the final STOP cycle SHALL start the next START with no idle gap.
REQ-019 SHALL ignore data_valid and data_in changes while data_ready is 0.
REQ-020 SHALL assert busy in every state except IDLE.
REQ-021 SHALL keep frame length at (NUM_BITS+2)*BIT_PERIOD cycles, plus BIT_PERIOD when parity is enabled.
REQ-022 SHALL, when BIT_PERIOD=1, advance one bit per cycle with no extra gap cycles.

Reset
REQ-023 SHALL on n_rst=0 immediately force state=IDLE, shift register all ones, counters to 0, serial_out=1, busy=0, frame_done=0.
REQ-024 SHALL abort any frame in progress on reset, without completing it.
REQ-025 SHALL assert data_ready=1 from the first clock edge after n_rst deasserts.

Configuration
REQ-026 SHALL use the macro FLEX_PTS_TX_PARITY_EN to select the PARITY state.
REQ-027 SHALL, with FLEX_PTS_TX_PARITY_EN defined, insert the PARITY state after DATA and send even parity over the captured word (XOR of all data bits).
REQ-028 SHALL, without FLEX_PTS_TX_PARITY_EN, omit the PARITY state entirely and go DATA -> STOP.

Structure
REQ-029 SHALL take the FSM state enum (IDLE, START, DATA, PARITY, STOP) from shared package pts_tx_pkg, which also holds the IDLE_LEVEL=1 constant.
REQ-030 SHALL implement the bit-period and bit-count timers with one reusable sub-module, flex_counter (parametrised width, clear, count_enable, rollover_val, rollover_flag), instantiated twice.

Verification
REQ-031 SHALL cover: NUM_BITS=8, SHIFT_MSB=1, BIT_PERIOD=4, accept 0xA5 -> serial_out 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; frame_done pulses once at cycle 40.
REQ-032 SHALL cover: SHIFT_MSB=0, accept 0x01 -> first data bit 1, then seven 0s.
REQ-033 SHALL cover: data_valid held high with 0x55 then 0xAA -> two frames back-to-back, no idle cycle between the STOP of frame 1 and the START of frame 2.
REQ-034 SHALL cover: n_rst pulsed low mid-DATA -> serial_out=1 and busy=0 immediately, data_ready=1 after release, and the next accept sends a clean frame.
REQ-035 SHALL cover: FLEX_PTS_TX_PARITY_EN defined, accept 0x07 -> parity bit 1 and frame length 44 cycles; accept 0x03 -> parity bit 0.
REQ-036 SHALL cover: BIT_PERIOD=1, accept 0xFF -> start bit low for 1 cycle, line high for the remaining 9 cycles, frame length 10 cycles.

Source files
------------

// File: rtl/pts_tx_pkg.sv
// Shared types and constants for the flex_pts_tx serial transmitter.
package pts_tx_pkg;

  // Transmitter FSM states; PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } pts_state_e;

  // Level of the serial line when nothing is being sent (and in the stop bit).
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/flex_counter.sv
// Reusable up-counter with synchronous clear, count enable and a
// programmable wrap value. rollover_flag is high while the count sits at
// rollover_val, so an enabled count in that cycle wraps back to zero and the
// next period starts without a gap.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise step and wrap at rollover_val.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // Count register, zeroed asynchronously on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/flex_pts_tx.sv
// Parallel-to-serial framed transmitter: start bit (0), NUM_BITS data bits,
// optional even-parity bit, stop bit (1); each bit lasts BIT_PERIOD clocks.
// Build option: define FLEX_PTS_TX_PARITY_EN to insert the PARITY bit.
//
// state  | meaning
// IDLE   | line high, waiting for a word, data_ready high
// START  | driving the start bit (0)
// DATA   | driving the shift-register end bit, shifting at each boundary
// PARITY | driving even parity of the captured word (parity builds only)
// STOP   | driving the stop bit (1); last cycle may accept the next word
module flex_pts_tx
  import pts_tx_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int SHIFT_MSB  = 1,
  parameter int BIT_PERIOD = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                serial_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int BW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int CW = $clog2(NUM_BITS);
  localparam logic [BW-1:0] BP_LAST = BW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] NB_LAST = CW'(NUM_BITS - 1);

  pts_state_e          state_q;
  logic [NUM_BITS-1:0] shreg_q;
  logic                serial_q;
  logic                busy_q;
`ifdef FLEX_PTS_TX_PARITY_EN
  logic                parity_q;
`endif

  logic                bit_end;
  logic                last_bit;
  logic                accept;
  logic                shift_end;
  logic                next_end;
  logic [NUM_BITS-1:0] shift_nxt;

  // Bit-period timer: held at zero in IDLE, wraps at every bit boundary.
  flex_counter #(.WIDTH(BW)) u_bit_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (state_q == IDLE),
    .count_enable  (state_q != IDLE),
    .rollover_val  (BP_LAST),
    .rollover_flag (bit_end)
  );

  // Data-bit counter: advances once per finished data bit, idle outside DATA.
  flex_counter #(.WIDTH(CW)) u_bit_count (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (state_q != DATA),
    .count_enable  ((state_q == DATA) && bit_end),
    .rollover_val  (NB_LAST),
    .rollover_flag (last_bit)
  );

  // Shift direction: the line always shows one end of the register and the
  // register refills with ones from the other end.
  if (SHIFT_MSB != 0) begin : g_msb_first
    assign shift_end = shreg_q[NUM_BITS-1];
    assign next_end  = shreg_q[NUM_BITS-2];
    assign shift_nxt = {shreg_q[NUM_BITS-2:0], 1'b1};
  end else begin : g_lsb_first
    assign shift_end = shreg_q[0];
    assign next_end  = shreg_q[1];
    assign shift_nxt = {1'b1, shreg_q[NUM_BITS-1:1]};
  end

  // The final stop cycle doubles as an accept slot so frames can abut.
  assign data_ready = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign accept     = data_valid && data_ready;
  assign frame_done = (state_q == STOP) && bit_end;
  assign serial_out = serial_q;
  assign busy       = busy_q;

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      shreg_q  <= '1;
      serial_q <= IDLE_LEVEL;
      busy_q   <= 1'b0;
`ifdef FLEX_PTS_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= START;
            shreg_q  <= data_in;
            serial_q <= 1'b0;
            busy_q   <= 1'b1;
`ifdef FLEX_PTS_TX_PARITY_EN
            parity_q <= ^data_in;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state_q  <= DATA;
            serial_q <= shift_end;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg_q <= shift_nxt;
            if (last_bit) begin
`ifdef FLEX_PTS_TX_PARITY_EN
              state_q  <= PARITY;
              serial_q <= parity_q;
`else
              state_q  <= STOP;
              serial_q <= IDLE_LEVEL;
`endif
            end else begin
              serial_q <= next_end;
            end
          end
        end
`ifdef FLEX_PTS_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q  <= STOP;
            serial_q <= IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (accept) begin
              state_q  <= START;
              shreg_q  <= data_in;
              serial_q <= 1'b0;
              busy_q   <= 1'b1;
`ifdef FLEX_PTS_TX_PARITY_EN
              parity_q <= ^data_in;
`endif
            end else begin
              state_q  <= IDLE;
              serial_q <= IDLE_LEVEL;
              busy_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          serial_q <= IDLE_LEVEL;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
